// File: rtl/relu.sv
// Purpose : per-lane ReLU on a packed vector of signed fixed-point lanes; clamps negative lanes to zero when en=1.
// Latency : 1 cycle, all outputs registered.
// Backpressure: none; one vector is accepted every cycle in_valid=1.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   en               1 = apply ReLU, 0 = bypass (sampled with in_valid)
//   in_valid/in_img  input vector, lane i = in_img[i*WIDTH +: WIDTH], lane 0 in the LSBs
//   out_valid        out_img/neg_mask carry a fresh result this cycle
//   out_img          registered result, same lane order as in_img
//   neg_mask         bit i = 1 when lane i was clamped in this result
module relu #(
    parameter int LANES = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [LANES*WIDTH-1:0] in_img,
    output logic                   out_valid,
    output logic [LANES*WIDTH-1:0] out_img,
    output logic [LANES-1:0]       neg_mask
);

    logic [LANES*WIDTH-1:0] nextImg;
    logic [LANES-1:0]       nextMask;

    // Sign is taken from the lane MSB alone, so the most negative code
    // clamps like any other negative value and zero passes untouched.
    always_comb begin
        nextImg  = in_img;
        nextMask = '0;
        for (int i = 0; i < LANES; i++) begin
            if (en && in_img[i*WIDTH + WIDTH - 1]) begin
                nextImg[i*WIDTH +: WIDTH] = '0;
                nextMask[i]               = 1'b1;
            end
        end
    end

    // Data registers only load on a valid input so the last result stays
    // visible on idle cycles; out_valid alone tells the consumer it is stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_img   <= '0;
            neg_mask  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_img  <= nextImg;
                neg_mask <= nextMask;
            end
        end
    end

endmodule

// File: tb/tb_relu.sv
// Purpose : directed-vector bench for relu with hand-computed expected results.
// Latency : each vector is driven, one clock edge is taken, outputs sampled 1 time unit later.
// Backpressure: not applicable; the DUT accepts every cycle.
module tb_relu;

    localparam int LANES = 4;
    localparam int WIDTH = 16;

    logic                   clk;
    logic                   rst;
    logic                   en;
    logic                   in_valid;
    logic [LANES*WIDTH-1:0] in_img;
    logic                   out_valid;
    logic [LANES*WIDTH-1:0] out_img;
    logic [LANES-1:0]       neg_mask;

    int checkCount;
    int errorCount;

    relu #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_img    (in_img),
        .out_valid (out_valid),
        .out_img   (out_img),
        .neg_mask  (neg_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one set of inputs, take one rising edge, land 1 unit past it.
    task automatic step(input logic r, input logic e, input logic v, input logic [63:0] img);
        rst      = r;
        en       = e;
        in_valid = v;
        in_img   = img;
        @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input logic v, input logic [63:0] img, input logic [3:0] mask);
        checkVal({tag, ".valid"}, {63'd0, out_valid}, {63'd0, v});
        checkVal({tag, ".img"},   out_img, img);
        checkVal({tag, ".mask"},  {60'd0, neg_mask}, {60'd0, mask});
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_img = '1;

        // Reset held two cycles with a valid all-ones vector present.
        step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        expectOut("reset1", 1'b0, 64'h0, 4'b0000);
        step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        expectOut("reset2", 1'b0, 64'h0, 4'b0000);

        // Bypass, all positive.
        step(1'b0, 1'b0, 1'b1, 64'h0205_63F1_0F47_005A);
        expectOut("bypassPos", 1'b1, 64'h0205_63F1_0F47_005A, 4'b0000);

        // Enabled, positive then negative back-to-back.
        step(1'b0, 1'b1, 1'b1, 64'h0205_63F1_0F47_005A);
        expectOut("enPos", 1'b1, 64'h0205_63F1_0F47_005A, 4'b0000);
        step(1'b0, 1'b1, 1'b1, 64'h9205_F3F1_8F47_805A);
        expectOut("enNeg", 1'b1, 64'h0, 4'b1111);

        // Bypass, all negative.
        step(1'b0, 1'b0, 1'b1, 64'h9205_F3F1_8F47_805A);
        expectOut("bypassNeg", 1'b1, 64'h9205_F3F1_8F47_805A, 4'b0000);

        // Enabled, mixed lanes: lanes 2 and 1 negative.
        step(1'b0, 1'b1, 1'b1, 64'h0205_F3F1_8F47_0F47);
        expectOut("enMixed", 1'b1, 64'h0205_0000_0000_0F47, 4'b0110);

        // Boundaries: 8000 clamps, 0000 and 7FFF pass, FFFF clamps (lanes 3 and 0).
        step(1'b0, 1'b1, 1'b1, 64'h8000_0000_7FFF_FFFF);
        expectOut("boundary", 1'b1, 64'h0000_0000_7FFF_0000, 4'b1001);

        // Idle cycle: outputs hold, valid drops; en and data are ignored.
        step(1'b0, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0);
        expectOut("hold", 1'b0, 64'h0000_0000_7FFF_0000, 4'b1001);

        // Alternating en on consecutive vectors of the same data.
        step(1'b0, 1'b0, 1'b1, 64'h7FFF_8001_0001_C000);
        expectOut("altEn0", 1'b1, 64'h7FFF_8001_0001_C000, 4'b0000);
        step(1'b0, 1'b1, 1'b1, 64'h7FFF_8001_0001_C000);
        expectOut("altEn1", 1'b1, 64'h7FFF_0000_0001_0000, 4'b0101);
        step(1'b0, 1'b0, 1'b1, 64'h7FFF_8001_0001_C000);
        expectOut("altEn0b", 1'b1, 64'h7FFF_8001_0001_C000, 4'b0000);

        // Reset mid-stream discards the vector presented alongside it.
        step(1'b1, 1'b1, 1'b1, 64'h8000_8000_8000_8000);
        expectOut("midReset", 1'b0, 64'h0, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 64'h8000_8000_8000_8000);
        expectOut("afterReset", 1'b0, 64'h0, 4'b0000);

        // First valid after reset.
        step(1'b0, 1'b1, 1'b1, 64'h0001_8000_0000_FFFE);
        expectOut("firstValid", 1'b1, 64'h0001_0000_0000_0000, 4'b0101);
        step(1'b0, 1'b1, 1'b0, 64'h0);
        expectOut("finalIdle", 1'b0, 64'h0001_0000_0000_0000, 4'b0101);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
